// File: rtl/output_bus_arbiter.sv
// Round-robin arbiter and data multiplexer for the shared output bus.
// Grants one requester at a time, forwards its fixed-length burst and aborts bursts that stall.
module output_bus_arbiter #(
   parameter int n_req          = 4,
   parameter int data_width     = 16,
   parameter int burst_len      = 4,
   parameter int timeout_cycles = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [n_req-1:0]              request,
   input  logic [n_req-1:0]              outReady,
   input  logic [n_req*data_width-1:0]   dataIn,
   input  logic                          errClear,
   output logic [n_req-1:0]              grant,
   output logic [data_width-1:0]         busData,
   output logic                          busValid,
   output logic [$clog2(n_req)-1:0]      busOwner,
   output logic                          busy,
   output logic                          timeoutErr
);

   localparam int OW = $clog2(n_req);
   localparam int BW = $clog2(burst_len + 1);
   localparam int TW = $clog2(timeout_cycles + 1);
   localparam logic [BW-1:0] BeatLast  = BW'(burst_len - 1);
   localparam logic [TW-1:0] StallLast = TW'(timeout_cycles - 1);
   localparam logic [OW-1:0] OwnerLast = OW'(n_req - 1);

   typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} state_t;

   state_t                state_q, state_d;
   logic [OW-1:0]         ptr_q, ptr_d;
   logic [BW-1:0]         beatCnt_q, beatCnt_d;
   logic [TW-1:0]         stallCnt_q, stallCnt_d;
   logic [n_req-1:0]      grant_q, grant_d;
   logic [data_width-1:0] busData_q, busData_d;
   logic                  busValid_q, busValid_d;
   logic [OW-1:0]         busOwner_q, busOwner_d;
   logic                  busy_q, busy_d;
   logic                  timeoutErr_q, timeoutErr_d;

   logic [OW-1:0]         winner;
   logic                  found;
   int                    idx;
   logic                  abort;
   logic                  ownerReady;
   logic [data_width-1:0] ownerData;

   assign ownerReady = outReady[busOwner_q];
   assign ownerData  = dataIn[int'(busOwner_q)*data_width +: data_width];

   // First set request bit at or after the priority pointer, wrapping around.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < n_req; k++) begin
         idx = (int'(ptr_q) + k) % n_req;
         if (!found && request[idx]) begin
            winner = OW'(idx);
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         beatCnt_q    <= '0;
         stallCnt_q   <= '0;
         grant_q      <= '0;
         busData_q    <= '0;
         busValid_q   <= 1'b0;
         busOwner_q   <= '0;
         busy_q       <= 1'b0;
         timeoutErr_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         beatCnt_q    <= beatCnt_d;
         stallCnt_q   <= stallCnt_d;
         grant_q      <= grant_d;
         busData_q    <= busData_d;
         busValid_q   <= busValid_d;
         busOwner_q   <= busOwner_d;
         busy_q       <= busy_d;
         timeoutErr_q <= timeoutErr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      beatCnt_d  = beatCnt_q;
      stallCnt_d = stallCnt_q;
      abort      = 1'b0;
      case (state_q)
         IDLE: begin
            if (|request) state_d = GRANT;
         end
         GRANT: begin
            state_d = XFER;
         end
         XFER: begin
            if (ownerReady) begin
               stallCnt_d = '0;
               beatCnt_d  = beatCnt_q + 1'b1;
               if (beatCnt_q == BeatLast) state_d = GAP;
            end else begin
               stallCnt_d = stallCnt_q + 1'b1;
               if (stallCnt_q == StallLast) begin
                  state_d = GAP;
                  abort   = 1'b1;
               end
            end
         end
         GAP: begin
            // Rotate priority past the requester just served.
            ptr_d      = (busOwner_q == OwnerLast) ? '0 : busOwner_q + 1'b1;
            beatCnt_d  = '0;
            stallCnt_d = '0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d      = '0;
      busOwner_d   = busOwner_q;
      busData_d    = busData_q;
      busValid_d   = 1'b0;
      busy_d       = (state_d == GRANT) || (state_d == XFER);
      timeoutErr_d = (timeoutErr_q & ~errClear) | abort;
      if (state_q == IDLE && (|request)) begin
         grant_d    = {{(n_req-1){1'b0}}, 1'b1} << winner;
         busOwner_d = winner;
      end
      if (state_q == XFER && ownerReady) begin
         busValid_d = 1'b1;
         busData_d  = ownerData;
      end
   end

   assign grant      = grant_q;
   assign busData    = busData_q;
   assign busValid   = busValid_q;
   assign busOwner   = busOwner_q;
   assign busy       = busy_q;
   assign timeoutErr = timeoutErr_q;

endmodule

// File: tb/tb_output_bus_arbiter.sv
// Directed bench for output_bus_arbiter: a vector table for a single burst
// plus hand-written sequences for contention, stalls, bus noise and reset.
module tb_output_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  request;
   logic [3:0]  outReady;
   logic [63:0] dataIn;
   logic        errClear;
   logic [3:0]  grant;
   logic [15:0] busData;
   logic        busValid;
   logic [1:0]  busOwner;
   logic        busy;
   logic        timeoutErr;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int lastBeat = 0;

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  rdy;
      logic [63:0] data;
      logic [3:0]  expGrant;
      logic        expValid;
      logic [15:0] expData;
      logic [1:0]  expOwner;
      logic        expBusy;
   } vec_t;

   vec_t vecs[8];

   output_bus_arbiter #(
      .n_req(4), .data_width(16), .burst_len(4), .timeout_cycles(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .request(request), .outReady(outReady),
      .dataIn(dataIn), .errClear(errClear), .grant(grant), .busData(busData),
      .busValid(busValid), .busOwner(busOwner), .busy(busy), .timeoutErr(timeoutErr)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] req, input logic [3:0] rdy, input logic [63:0] data);
      request  = req;
      outReady = rdy;
      dataIn   = data;
      tick();
   endtask

   task automatic doReset;
      rst_n    = 1'b0;
      request  = '0;
      outReady = '0;
      dataIn   = '0;
      errClear = 1'b0;
      #12;
      rst_n = 1'b1;
   endtask

   task automatic waitGrant(input int who);
      int n;
      outReady = '0;
      tick();
      n = 1;
      while (grant == 4'b0 && n < 20) begin
         tick();
         n++;
      end
      if (grant == 4'b0) begin
         checks++;
         errors++;
         $display("[TB] FAIL grant wait: no grant after %0d cycles, expected %0h", n, 64'(1) << who);
      end else begin
         checkOutput("grant onehot", 64'(grant), 64'(1) << who);
         checkOutput("owner", 64'(busOwner), 64'(who));
      end
   endtask

   task automatic serveBurst(input int who, input logic [15:0] base, input int expGap);
      waitGrant(who);
      if (expGap > 0) checkOutput("grant gap", 64'(cycle - lastBeat), 64'(expGap));
      tick();
      checkOutput("grant pulse width", 64'(grant), 64'(0));
      for (int b = 0; b < 4; b++) begin
         outReady = '0;
         outReady[who] = 1'b1;
         dataIn[who*16 +: 16] = base + 16'(b);
         tick();
         checkOutput("beat valid", 64'(busValid), 64'(1));
         checkOutput("beat data", 64'(busData), 64'(base + 16'(b)));
      end
      lastBeat = cycle;
      checkOutput("busy after burst", 64'(busy), 64'(0));
      outReady = '0;
   endtask

   initial begin
      vecs[0] = '{4'b0100, 4'b0000, {16'h1111, 16'h0000, 16'h3333, 16'h4444}, 4'b0100, 1'b0, 16'h0000, 2'd2, 1'b1};
      vecs[1] = '{4'b0000, 4'b0001, {16'h1111, 16'h0000, 16'h3333, 16'h4444}, 4'b0000, 1'b0, 16'h0000, 2'd2, 1'b1};
      vecs[2] = '{4'b0000, 4'b0100, {16'h1111, 16'hA000, 16'h3333, 16'h4444}, 4'b0000, 1'b1, 16'hA000, 2'd2, 1'b1};
      vecs[3] = '{4'b0000, 4'b0101, {16'h1111, 16'hA001, 16'h3333, 16'h4444}, 4'b0000, 1'b1, 16'hA001, 2'd2, 1'b1};
      vecs[4] = '{4'b0000, 4'b0100, {16'h1111, 16'hA002, 16'h3333, 16'h4444}, 4'b0000, 1'b1, 16'hA002, 2'd2, 1'b1};
      vecs[5] = '{4'b0000, 4'b0100, {16'h1111, 16'hA003, 16'h3333, 16'h4444}, 4'b0000, 1'b1, 16'hA003, 2'd2, 1'b0};
      vecs[6] = '{4'b0000, 4'b0000, {16'h1111, 16'hA003, 16'h3333, 16'h4444}, 4'b0000, 1'b0, 16'hA003, 2'd2, 1'b0};
      vecs[7] = '{4'b0000, 4'b0100, {16'h1111, 16'hBEEF, 16'h3333, 16'h4444}, 4'b0000, 1'b0, 16'hA003, 2'd2, 1'b0};

      rst_n    = 1'b0;
      request  = '0;
      outReady = '0;
      dataIn   = '0;
      errClear = 1'b0;
      #3;
      checkOutput("reset grant", 64'(grant), 64'(0));
      checkOutput("reset busData", 64'(busData), 64'(0));
      checkOutput("reset busValid", 64'(busValid), 64'(0));
      checkOutput("reset busOwner", 64'(busOwner), 64'(0));
      checkOutput("reset busy", 64'(busy), 64'(0));
      checkOutput("reset timeoutErr", 64'(timeoutErr), 64'(0));
      doReset();

      $display("[TB] single requester table");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].req, vecs[i].rdy, vecs[i].data);
         checkOutput("table grant", 64'(grant), 64'(vecs[i].expGrant));
         checkOutput("table busValid", 64'(busValid), 64'(vecs[i].expValid));
         checkOutput("table busData", 64'(busData), 64'(vecs[i].expData));
         checkOutput("table busOwner", 64'(busOwner), 64'(vecs[i].expOwner));
         checkOutput("table busy", 64'(busy), 64'(vecs[i].expBusy));
         checkOutput("table timeoutErr", 64'(timeoutErr), 64'(0));
      end

      $display("[TB] contention and wrap");
      doReset();
      request = 4'b1111;
      serveBurst(0, 16'h1000, -1);
      serveBurst(1, 16'h2000, 2);
      serveBurst(2, 16'h3000, 2);
      serveBurst(3, 16'h4000, 2);
      serveBurst(0, 16'h1100, 2);
      request = 4'b1001;
      serveBurst(3, 16'h4100, 2);
      serveBurst(0, 16'h1200, 2);

      $display("[TB] stalled burst");
      request = 4'b0010;
      waitGrant(1);
      request = 4'b0000;
      tick();
      for (int b = 0; b < 2; b++) begin
         outReady = 4'b0010;
         dataIn[16 +: 16] = 16'h5500 + 16'(b);
         tick();
         checkOutput("stall beat data", 64'(busData), 64'(16'h5500 + 16'(b)));
      end
      outReady = 4'b0000;
      for (int s = 1; s <= 7; s++) begin
         tick();
         checkOutput("stall busValid", 64'(busValid), 64'(0));
         checkOutput("stall busData hold", 64'(busData), 64'(16'h5501));
         checkOutput("stall busy", 64'(busy), 64'(1));
         checkOutput("stall no error yet", 64'(timeoutErr), 64'(0));
      end
      errClear = 1'b1;
      tick();
      checkOutput("abort sets error over clear", 64'(timeoutErr), 64'(1));
      checkOutput("abort busy", 64'(busy), 64'(0));
      errClear = 1'b0;
      tick();
      tick();
      checkOutput("error sticky", 64'(timeoutErr), 64'(1));
      errClear = 1'b1;
      tick();
      checkOutput("error cleared", 64'(timeoutErr), 64'(0));
      errClear = 1'b0;

      $display("[TB] non-owner noise");
      request = 4'b0001;
      waitGrant(0);
      request = 4'b0000;
      tick();
      dataIn[32 +: 16] = 16'hFFFF;
      for (int b = 0; b < 4; b++) begin
         outReady = 4'b0101;
         dataIn[0 +: 16] = 16'h1230 + 16'(b);
         tick();
         checkOutput("noise beat valid", 64'(busValid), 64'(1));
         checkOutput("noise beat data", 64'(busData), 64'(16'h1230 + 16'(b)));
         outReady = 4'b0100;
         tick();
         checkOutput("noise ignored valid", 64'(busValid), 64'(0));
         checkOutput("noise ignored data", 64'(busData), 64'(16'h1230 + 16'(b)));
      end
      outReady = 4'b0000;

      $display("[TB] reset mid-burst");
      request = 4'b0010;
      serveBurst(1, 16'h7700, -1);
      request = 4'b1000;
      waitGrant(3);
      request = 4'b0000;
      tick();
      for (int b = 0; b < 2; b++) begin
         outReady = 4'b1000;
         dataIn[48 +: 16] = 16'h9900 + 16'(b);
         tick();
         checkOutput("pre-reset beat", 64'(busData), 64'(16'h9900 + 16'(b)));
      end
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset busValid", 64'(busValid), 64'(0));
      checkOutput("async reset busy", 64'(busy), 64'(0));
      checkOutput("async reset busData", 64'(busData), 64'(0));
      checkOutput("async reset busOwner", 64'(busOwner), 64'(0));
      checkOutput("async reset timeoutErr", 64'(timeoutErr), 64'(0));
      #3;
      rst_n = 1'b1;
      request = 4'b0110;
      waitGrant(1);
      request = 4'b0000;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
